// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with enable-gated prescaler, sync clear, clamped load, wrap or saturate.
// Latency: o_cnt/o_tc/o_step update on the stepping edge; no backpressure, i_en simply freezes state.
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MOD_N    = 10,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_step
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_ONE = PW'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD_N - 1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MOD_N);

    generate
        if (MOD_N < 2 || MOD_N > (1 << WIDTH) || PRESCALE < 1 || PRESCALE > 65535) begin : g_param_check
            $error("mod_updown_counter: illegal MOD_N or PRESCALE parameter");
        end
    endgenerate

    logic [PW-1:0]    pre;
    logic             step;
    logic             at_end;
    logic [WIDTH-1:0] load_cl;

    assign step    = i_en && (pre == PRE_MAX);
    assign at_end  = i_up ? (o_cnt == CNT_MAX) : (o_cnt == '0);
    // Out-of-range load values clamp to the top of the count range.
    assign load_cl = ({1'b0, i_load_val} < MOD_W) ? i_load_val : CNT_MAX;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt  <= '0;
            o_tc   <= 1'b0;
            o_step <= 1'b0;
            pre    <= '0;
        end else if (i_clr) begin
            o_cnt  <= '0;
            o_tc   <= 1'b0;
            o_step <= 1'b0;
            pre    <= '0;
        end else if (i_load) begin
            o_cnt  <= load_cl;
            o_tc   <= 1'b0;
            o_step <= 1'b0;
            pre    <= '0;
        end else if (step) begin
            pre    <= '0;
            o_step <= 1'b1;
            o_tc   <= at_end;
            if (!at_end) begin
                o_cnt <= i_up ? (o_cnt + CNT_ONE) : (o_cnt - CNT_ONE);
            end else if (SATURATE == 0) begin
                o_cnt <= i_up ? '0 : CNT_MAX;
            end
        end else begin
            o_tc   <= 1'b0;
            o_step <= 1'b0;
            if (i_en) begin
                pre <= pre + PRE_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: wrap, saturate, prescaled and cascaded instances against a reference model.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
    logic [3:0] lv = '0;
    logic       c_en = 1'b0, c_clr = 1'b0;

    logic [3:0] a_cnt, b_cnt, c_cnt, d0_cnt, d1_cnt;
    logic       a_tc, b_tc, c_tc, d0_tc, d1_tc;
    logic       a_st, b_st, c_st, d0_st, d1_st;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MOD_N(10), .PRESCALE(1), .SATURATE(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_clr(clr), .i_load(load),
        .i_load_val(lv), .o_cnt(a_cnt), .o_tc(a_tc), .o_step(a_st));
    mod_updown_counter #(.WIDTH(4), .MOD_N(10), .PRESCALE(1), .SATURATE(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_clr(clr), .i_load(load),
        .i_load_val(lv), .o_cnt(b_cnt), .o_tc(b_tc), .o_step(b_st));
    mod_updown_counter #(.WIDTH(4), .MOD_N(10), .PRESCALE(4), .SATURATE(0)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_clr(clr), .i_load(load),
        .i_load_val(lv), .o_cnt(c_cnt), .o_tc(c_tc), .o_step(c_st));
    mod_updown_counter #(.WIDTH(4), .MOD_N(10), .PRESCALE(1), .SATURATE(0)) dut_d0 (
        .i_clk(clk), .i_rst(rst), .i_en(c_en), .i_up(1'b1), .i_clr(c_clr), .i_load(1'b0),
        .i_load_val(4'd0), .o_cnt(d0_cnt), .o_tc(d0_tc), .o_step(d0_st));
    mod_updown_counter #(.WIDTH(4), .MOD_N(10), .PRESCALE(1), .SATURATE(0)) dut_d1 (
        .i_clk(clk), .i_rst(rst), .i_en(d0_tc), .i_up(1'b1), .i_clr(c_clr), .i_load(1'b0),
        .i_load_val(4'd0), .o_cnt(d1_cnt), .o_tc(d1_tc), .o_step(d1_st));

    // Reference state: ph counts enabled cycles since the last step.
    typedef struct {
        int cnt;
        int ph;
        int tc;
        int stp;
    } mst_t;

    mst_t ma, mb, mc, m0, m1;
    mst_t zero_st = '{0, 0, 0, 0};

    function automatic mst_t mstep(mst_t s, bit e, bit u, bit c, bit l, int v, int n, int p, bit sat);
        mst_t r = s;
        if (c) begin
            r = '{0, 0, 0, 0};
        end else if (l) begin
            r.cnt = (v < n) ? v : n - 1;
            r.ph  = 0;
            r.tc  = 0;
            r.stp = 0;
        end else if (e && (s.ph + 1 == p)) begin
            r.ph  = 0;
            r.stp = 1;
            if (u) begin
                r.tc  = (s.cnt == n - 1) ? 1 : 0;
                r.cnt = (r.tc == 1 && sat) ? s.cnt : (s.cnt + 1) % n;
            end else begin
                r.tc  = (s.cnt == 0) ? 1 : 0;
                r.cnt = (r.tc == 1 && sat) ? s.cnt : (s.cnt + n - 1) % n;
            end
        end else begin
            r.tc  = 0;
            r.stp = 0;
            if (e) r.ph = s.ph + 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string nm, input logic [3:0] cnt, input logic tc, input logic st, input mst_t m);
        chk({nm, ".cnt"}, 32'(cnt), 32'(m.cnt));
        chk({nm, ".tc"},  32'(tc),  32'(m.tc));
        chk({nm, ".step"}, 32'(st), 32'(m.stp));
    endtask

    task automatic chk_all();
        chk_dut("a", a_cnt, a_tc, a_st, ma);
        chk_dut("b", b_cnt, b_tc, b_st, mb);
        chk_dut("c", c_cnt, c_tc, c_st, mc);
        chk_dut("d0", d0_cnt, d0_tc, d0_st, m0);
        chk_dut("d1", d1_cnt, d1_tc, d1_st, m1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            ma = zero_st; mb = zero_st; mc = zero_st; m0 = zero_st; m1 = zero_st;
        end else begin
            ma = mstep(ma, en, up, clr, load, int'(lv), 10, 1, 1'b0);
            mb = mstep(mb, en, up, clr, load, int'(lv), 10, 1, 1'b1);
            mc = mstep(mc, en, up, clr, load, int'(lv), 10, 4, 1'b0);
            m1 = mstep(m1, m0.tc != 0, 1'b1, c_clr, 1'b0, 0, 10, 1, 1'b0);
            m0 = mstep(m0, c_en, 1'b1, c_clr, 1'b0, 0, 10, 1, 1'b0);
        end
        #1;
        chk_all();
    endtask

    initial begin
        int s1_steps;
        int s1_tcs;

        ma = zero_st; mb = zero_st; mc = zero_st; m0 = zero_st; m1 = zero_st;

        // Reset, then idle with enable low.
        tick(); tick();
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_c_step", 32'(c_st), 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_a_cnt", 32'(a_cnt), 0);

        // Up count through the wrap.
        en = 1'b1; up = 1'b1;
        repeat (9) tick();
        chk("up_a_at9", 32'(a_cnt), 9);
        tick();
        chk("wrap_a_cnt", 32'(a_cnt), 0);
        chk("wrap_a_tc", 32'(a_tc), 1);
        chk("sat_b_hold", 32'(b_cnt), 9);
        repeat (3) tick();

        // Asynchronous reset mid-cycle.
        #3 rst = 1'b1;
        #1;
        chk("arst_a_cnt", 32'(a_cnt), 0);
        chk("arst_a_tc", 32'(a_tc), 0);
        chk("arst_c_cnt", 32'(c_cnt), 0);
        ma = zero_st; mb = zero_st; mc = zero_st; m0 = zero_st; m1 = zero_st;
        tick();
        rst = 1'b0;

        // Down from zero: wrap vs saturate.
        en = 1'b1; up = 1'b0;
        tick();
        chk("down_a_cnt", 32'(a_cnt), 9);
        chk("down_a_tc", 32'(a_tc), 1);
        chk("down_b_cnt", 32'(b_cnt), 0);
        chk("down_b_tc", 32'(b_tc), 1);
        tick();
        chk("down_b_tc2", 32'(b_tc), 1);

        // Prescaler: 16 enabled cycles give 4 steps, then a 3-cycle enable gap.
        clr = 1'b1; tick(); clr = 1'b0;
        up = 1'b1;
        repeat (16) tick();
        chk("pre_c_cnt", 32'(c_cnt), 4);
        repeat (2) tick();
        en = 1'b0; repeat (3) tick();
        en = 1'b1; repeat (2) tick();
        chk("pre_gap_c_step", 32'(c_st), 1);
        chk("pre_gap_c_cnt", 32'(c_cnt), 5);

        // Load clamping, clear over load, load at the prescaler terminal.
        load = 1'b1; lv = 4'd12; tick();
        chk("load_clamp_a", 32'(a_cnt), 9);
        clr = 1'b1; lv = 4'd5; tick();
        chk("clr_over_load", 32'(a_cnt), 0);
        clr = 1'b0; load = 1'b0;
        repeat (3) tick();
        load = 1'b1; lv = 4'd2; tick(); load = 1'b0;
        chk("load_term_c_cnt", 32'(c_cnt), 2);
        chk("load_term_c_step", 32'(c_st), 0);
        repeat (3) tick();
        chk("load_term_no_step", 32'(c_cnt), 2);
        tick();
        chk("load_term_next", 32'(c_cnt), 3);

        // Two-digit cascade: 100 steps from 00.
        en = 1'b0;
        c_clr = 1'b1; tick(); c_clr = 1'b0;
        s1_steps = 0; s1_tcs = 0;
        c_en = 1'b1;
        for (int i = 0; i < 101; i++) begin
            if (i == 100) c_en = 1'b0;
            tick();
            if (d1_st) s1_steps++;
            if (d1_tc) s1_tcs++;
        end
        chk("casc_d0", 32'(d0_cnt), 0);
        chk("casc_d1", 32'(d1_cnt), 0);
        chk("casc_d1_steps", 32'(s1_steps), 10);
        chk("casc_d1_tcs", 32'(s1_tcs), 1);

        // Randomized operation against the model.
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            up    = 1'($urandom);
            clr   = ($urandom_range(0, 31) == 0);
            load  = ($urandom_range(0, 15) == 0);
            lv    = 4'($urandom);
            c_en  = 1'($urandom);
            c_clr = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised modulo-N up/down counter with built-in prescaler, synchronous clear, parallel load, and wrap or saturate mode. It is the general counting primitive for the seven-segment multiplexing datapath. Typical uses are the digit-select scan counter (prescaled refresh tick) and cascaded BCD digit counters, chained through the terminal-count output. It replaces the fixed 4-bit up/down counter.

## Interface
Parameters:
- WIDTH, 4, counter width in bits
- MOD_N, 10, modulus; count range 0..MOD_N-1; legal 2 <= MOD_N <= 2**WIDTH
- PRESCALE, 1, enabled cycles per count step; legal 1..65535; 1 = step every enabled cycle
- SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends

Ports:
- i_clk  in  1  clock; all logic is rising-edge
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  1  count enable; gates both the prescaler and the step
- i_up  in  1  direction; 1 = up, 0 = down; sampled at the step cycle
- i_clr  in  1  synchronous clear
- i_load  in  1  synchronous parallel load
- i_load_val  in  WIDTH  load value
- o_cnt  out  WIDTH  current count (registered)
- o_tc  out  1  terminal-count pulse (registered)
- o_step  out  1  prescaler step strobe (registered); high in the cycle after a step was taken

## Operation
- Internal prescaler register pre: width clog2(PRESCALE), minimum 1 bit. Range 0..PRESCALE-1.
- Step condition: i_en && (pre == PRESCALE-1).
- Prescaler behaviour:
  - On a step, pre returns to 0.
  - Otherwise, when i_en is high, pre increments.
  - When i_en is low, pre holds.
- Priority, highest first: i_rst, i_clr, i_load, step, hold.
- i_clr:
  - o_cnt <= 0, pre <= 0, o_tc <= 0, o_step <= 0.
  - Overrides i_load and i_en in the same cycle.
- i_load:
  - o_cnt <= i_load_val when i_load_val < MOD_N; otherwise o_cnt <= MOD_N-1 (clamped).
  - pre <= 0, o_tc <= 0, o_step <= 0. No step is taken that cycle.
- Step, up direction:
  - If o_cnt == MOD_N-1: o_cnt <= 0 when SATURATE=0, or holds when SATURATE=1. o_tc <= 1 in both modes.
  - Else: o_cnt <= o_cnt+1, o_tc <= 0.
- Step, down direction:
  - If o_cnt == 0: o_cnt <= MOD_N-1 when SATURATE=0, or holds when SATURATE=1. o_tc <= 1 in both modes.
  - Else: o_cnt <= o_cnt-1, o_tc <= 0.
- Every step sets o_step <= 1. Non-step cycles set o_step <= 0 and o_tc <= 0.
- Arithmetic:
  - Compare and increment in WIDTH bits. No overflow is possible because MOD_N <= 2**WIDTH.
  - When MOD_N == 2**WIDTH, wrap equals natural rollover; the o_tc rules are unchanged.
- Cascading: connect o_tc of stage k to i_en of stage k+1 (stage k+1 uses PRESCALE=1). That stage then steps in the cycle after stage k wraps.
- Illegal parameters (MOD_N out of range, PRESCALE < 1): elaboration-time error via a generate-block check.

## Timing
- Reset: o_cnt = 0, o_tc = 0, o_step = 0, pre = 0, all immediately on i_rst assertion, independent of the clock.
- Release: the first step can occur no earlier than the PRESCALE-th enabled edge after deassertion.
- Latency: o_cnt, o_tc and o_step all update on the same edge that takes the step; o_tc and o_step are coincident with the new o_cnt value.
- Step rate: with i_en held high, one step every PRESCALE cycles. o_tc and o_step are single-cycle pulses, except with PRESCALE=1 and continuous enable, where o_step stays high.
- Simultaneous i_clr and i_load: clear wins.
- i_load coinciding with a prescaler terminal: the load wins and the prescaler phase restarts.
- i_up changing mid-prescale: only the value at the step edge matters.
- i_en low: o_cnt and pre are frozen; o_tc and o_step drop to 0 on the next edge.
- Reset mid-count: all state clears asynchronously. No partial step is taken after release.

## Test plan
- Reset/hold: WIDTH=4, MOD_N=10, PRESCALE=1. Assert i_rst mid-cycle -> o_cnt=0, o_tc=0 immediately. Hold i_en=0 for 5 cycles -> o_cnt stays 0.
- Up wrap: i_en=1, i_up=1 from 0 -> o_cnt counts 1..9, then 0. o_tc=1 only on the edge where 9->0; o_step high throughout.
- Down wrap and saturate: i_up=0 from 0 -> o_cnt=9 with o_tc=1. With SATURATE=1, down steps from 0 -> o_cnt stays 0 and o_tc pulses on each step.
- Prescaler: PRESCALE=4, i_en=1 for 16 cycles -> 4 steps, o_cnt=4, o_step high every 4th cycle. Drop i_en for 3 cycles mid-phase -> step timing shifts by exactly 3 cycles.
- Load/clear priority: i_load_val=12 with MOD_N=10 -> o_cnt=9. i_load=1 and i_clr=1 with i_load_val=5 -> o_cnt=0. Load at a prescaler terminal -> no step that cycle; next step 4 enabled cycles later.
- Cascade: two MOD_N=10 stages, stage 0 o_tc driving stage 1 i_en, 100 steps from 00 -> digits read 00 after wrapping 99->00. Stage 1 increments exactly 10 times over the 100 steps; the last increment (9->0) pulses stage 1 o_tc once.
